// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C command sequencer: FSM state encoding and command-entry layout.
package i2c_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StActive,
    StDone
  } seq_state_e;

  // Command entry, MSB to LSB: addr[6:0], rw, reg[7:0], data[7:0].
  localparam int unsigned CmdWidth   = 24;
  localparam int unsigned DataOffset = 0;
  localparam int unsigned RegOffset  = 8;
  localparam int unsigned RwOffset   = 16;
  localparam int unsigned AddrOffset = 17;

  function automatic logic [CmdWidth-1:0] pack_cmd(input logic [6:0] addr, input logic rw,
                                                   input logic [7:0] reg_idx,
                                                   input logic [7:0] data);
    return {addr, rw, reg_idx, data};
  endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; Depth must be a power of two.
module i2c_cmd_fifo #(
  parameter int unsigned Width = 24,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PtrW'(1);
      if (pop_i)  rptr_q <= rptr_q + PtrW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues I2C register commands and issues them one at a time to an I2C controller.
// Optional busy watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [6:0] cmd_addr_i,
  input  logic       cmd_rw_i,
  input  logic [7:0] cmd_reg_i,
  input  logic [7:0] cmd_data_i,
  output logic       rsp_valid_o,
  output logic       rsp_rw_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_error_o,
  output logic [6:0] ctl_address_o,
  output logic       ctl_rw_o,
  output logic [7:0] ctl_register_o,
  output logic [7:0] ctl_data_o,
  input  logic [7:0] ctl_data_i,
  output logic       ctl_execute_o,
  input  logic       ctl_busy_i,
  output logic       seq_busy_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CmdWidth-1:0] fifo_rdata;
  logic [CntW-1:0]     fifo_count;

  seq_state_e state_q;
  logic [6:0] ctl_address_q;
  logic       ctl_rw_q;
  logic [7:0] ctl_register_q, ctl_data_q;
  logic       ctl_execute_q;
  logic       rsp_valid_q, rsp_rw_q;
  logic [7:0] rsp_data_q;
  logic       tmo_hit;

  assign cmd_ready_o = ~fifo_full;
  assign fifo_push   = cmd_valid_i & ~fifo_full;
  // Launch only once the controller has gone quiet, including after a mid-transfer reset.
  assign fifo_pop    = (state_q == StIdle) & ~fifo_empty & ~ctl_busy_i;
  assign seq_busy_o  = (fifo_count != '0) | (state_q != StIdle);

  i2c_cmd_fifo #(
    .Width (CmdWidth),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (pack_cmd(cmd_addr_i, cmd_rw_i, cmd_reg_i, cmd_data_i)),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_cnt_q;
  logic            rsp_error_q;
  // Fires on the last permitted cycle so the wait lasts exactly TIMEOUT_CYCLES.
  assign tmo_hit     = (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
  assign rsp_error_o = rsp_error_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
  assign rsp_error_o    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      ctl_address_q  <= '0;
      ctl_rw_q       <= 1'b0;
      ctl_register_q <= '0;
      ctl_data_q     <= '0;
      ctl_execute_q  <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rw_q       <= 1'b0;
      rsp_data_q     <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
      tmo_cnt_q      <= '0;
      rsp_error_q    <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (fifo_pop) begin
            ctl_address_q  <= fifo_rdata[AddrOffset +: 7];
            ctl_rw_q       <= fifo_rdata[RwOffset];
            ctl_register_q <= fifo_rdata[RegOffset +: 8];
            ctl_data_q     <= fifo_rdata[DataOffset +: 8];
            ctl_execute_q  <= 1'b1;
            state_q        <= StLaunch;
`ifdef I2C_SEQ_TIMEOUT_EN
            tmo_cnt_q      <= '0;
`endif
          end
        end
        StLaunch: begin
`ifdef I2C_SEQ_TIMEOUT_EN
          tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
`endif
          if (ctl_busy_i) begin
            ctl_execute_q <= 1'b0;
            state_q       <= StActive;
`ifdef I2C_SEQ_TIMEOUT_EN
            tmo_cnt_q     <= '0;
`endif
          end else if (tmo_hit) begin
            ctl_execute_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rw_q      <= ctl_rw_q;
            rsp_data_q    <= '0;
            state_q       <= StDone;
`ifdef I2C_SEQ_TIMEOUT_EN
            rsp_error_q   <= 1'b1;
`endif
          end
        end
        StActive: begin
`ifdef I2C_SEQ_TIMEOUT_EN
          tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
`endif
          if (!ctl_busy_i) begin
            rsp_valid_q <= 1'b1;
            rsp_rw_q    <= ctl_rw_q;
            rsp_data_q  <= ctl_rw_q ? ctl_data_i : 8'h00;
            state_q     <= StDone;
`ifdef I2C_SEQ_TIMEOUT_EN
            rsp_error_q <= 1'b0;
`endif
          end else if (tmo_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_rw_q    <= ctl_rw_q;
            rsp_data_q  <= '0;
            state_q     <= StDone;
`ifdef I2C_SEQ_TIMEOUT_EN
            rsp_error_q <= 1'b1;
`endif
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ctl_address_o  = ctl_address_q;
  assign ctl_rw_o       = ctl_rw_q;
  assign ctl_register_o = ctl_register_q;
  assign ctl_data_o     = ctl_data_q;
  assign ctl_execute_o  = ctl_execute_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rw_o       = rsp_rw_q;
  assign rsp_data_o     = rsp_data_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Randomized self-checking bench for i2c_cmd_sequencer with a behavioural I2C controller model.
module tb_i2c_cmd_sequencer;

  typedef struct packed {
    logic [6:0] a;
    logic       rw;
    logic [7:0] r;
    logic [7:0] d;
  } cmd_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [6:0] cmd_addr_i = '0;
  logic       cmd_rw_i = 1'b0;
  logic [7:0] cmd_reg_i = '0;
  logic [7:0] cmd_data_i = '0;
  logic       rsp_valid_o, rsp_rw_o, rsp_error_o;
  logic [7:0] rsp_data_o;
  logic [6:0] ctl_address_o;
  logic       ctl_rw_o;
  logic [7:0] ctl_register_o, ctl_data_o;
  logic [7:0] ctl_data_i = '0;
  logic       ctl_execute_o;
  logic       ctl_busy_i = 1'b0;
  logic       seq_busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_rsp    = 0;

  logic [7:0] rd_mem [256];
  cmd_t       exp_q [$];
  cmd_t       cur;
  logic       have_inflight = 1'b0;
  int         launch_cyc = 0;
  logic       stall = 1'b0;
  logic       long_mode = 1'b0;
  logic       tmo_mode = 1'b0;
  logic       prev_exec = 1'b0, prev_busy = 1'b0, prev_rst = 1'b1, prev_rsp = 1'b0;

  i2c_cmd_sequencer #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_addr_i     (cmd_addr_i),
    .cmd_rw_i       (cmd_rw_i),
    .cmd_reg_i      (cmd_reg_i),
    .cmd_data_i     (cmd_data_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rw_o       (rsp_rw_o),
    .rsp_data_o     (rsp_data_o),
    .rsp_error_o    (rsp_error_o),
    .ctl_address_o  (ctl_address_o),
    .ctl_rw_o       (ctl_rw_o),
    .ctl_register_o (ctl_register_o),
    .ctl_data_o     (ctl_data_o),
    .ctl_data_i     (ctl_data_i),
    .ctl_execute_o  (ctl_execute_o),
    .ctl_busy_i     (ctl_busy_i),
    .seq_busy_o     (seq_busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Controller model: after execute, optional delay, busy for a while, then read data appears.
  initial begin
    int         d, l;
    logic [7:0] cap_reg;
    forever begin
      @(posedge clk_i); #1;
      if (ctl_execute_o === 1'b1 && !stall) begin
        cap_reg = ctl_register_o;
        d = long_mode ? 0 : int'($urandom_range(0, 2));
        repeat (d) begin @(posedge clk_i); #1; end
        ctl_busy_i = 1'b1;
        ctl_data_i = 8'($urandom);
        l = long_mode ? 30 : int'($urandom_range(1, 5));
        repeat (l) begin @(posedge clk_i); #1; end
        ctl_data_i = rd_mem[cap_reg];
        ctl_busy_i = 1'b0;
      end
    end
  end

  // Reference: commands launch and complete strictly in push order, one at a time.
  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_q.delete();
      have_inflight = 1'b0;
    end else begin
      if (ctl_execute_o && !prev_exec) begin
        if (exp_q.size() == 0 || have_inflight) begin
          check_eq("launch_spurious", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          have_inflight = 1'b1;
          launch_cyc = cyc;
          check_eq("ctl_address", 32'(ctl_address_o), 32'(cur.a));
          check_eq("ctl_rw", 32'(ctl_rw_o), 32'(cur.rw));
          check_eq("ctl_register", 32'(ctl_register_o), 32'(cur.r));
          check_eq("ctl_data", 32'(ctl_data_o), 32'(cur.d));
        end
      end
      if (prev_exec && prev_busy && !prev_rst) check_eq("exec_drop", 32'(ctl_execute_o), 0);
      if (prev_exec && !prev_busy && !prev_rst && !tmo_mode)
        check_eq("exec_hold", 32'(ctl_execute_o), 1);
      if (rsp_valid_o) begin
        if (prev_rsp) check_eq("rsp_pulse_width", 2, 1);
        if (!have_inflight) begin
          check_eq("rsp_spurious", 1, 0);
        end else begin
          check_eq("rsp_rw", 32'(rsp_rw_o), 32'(cur.rw));
          if (tmo_mode) begin
            check_eq("tmo_data", 32'(rsp_data_o), 0);
            check_eq("tmo_error", 32'(rsp_error_o), 1);
            check_eq("tmo_latency", 32'(cyc - launch_cyc), 16);
          end else begin
            check_eq("rsp_data", 32'(rsp_data_o), cur.rw ? 32'(rd_mem[cur.r]) : 0);
            check_eq("rsp_error", 32'(rsp_error_o), 0);
          end
          have_inflight = 1'b0;
          n_rsp++;
        end
      end
    end
    prev_exec = ctl_execute_o;
    prev_busy = ctl_busy_i;
    prev_rst  = rst_i;
    prev_rsp  = rsp_valid_o;
  end

  task automatic push_cmd(input logic [6:0] a, input logic rw, input logic [7:0] r,
                          input logic [7:0] d);
    int   waited;
    logic acc;
    cmd_t c;
    @(posedge clk_i); #1;
    cmd_addr_i  = a;
    cmd_rw_i    = rw;
    cmd_reg_i   = r;
    cmd_data_i  = d;
    cmd_valid_i = 1'b1;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < 300) begin
      @(negedge clk_i);
      acc = cmd_ready_o;
      @(posedge clk_i); #1;
      waited++;
    end
    cmd_valid_i = 1'b0;
    c = '{a: a, rw: rw, r: r, d: d};
    if (acc) exp_q.push_back(c);
    else check_eq("push_timeout", 0, 1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!(exp_q.size() == 0 && !have_inflight && !seq_busy_o && !ctl_busy_i &&
                 !cmd_valid_i) && n < budget);
    check_eq("drain_timeout", 32'(n >= budget), 0);
  endtask

  initial begin
    int base, n;
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    for (int i = 0; i < 256; i++) rd_mem[i] = 8'($urandom);
    rd_mem[8'h0F] = 8'hA5;

    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_ready", 32'(cmd_ready_o), 1);
    check_eq("rst_seq_busy", 32'(seq_busy_o), 0);
    check_eq("rst_exec", 32'(ctl_execute_o), 0);
    check_eq("rst_rsp_valid", 32'(rsp_valid_o), 0);
    check_eq("rst_rsp", {22'b0, rsp_rw_o, rsp_error_o, rsp_data_o}, 0);
    check_eq("rst_ctl", {8'b0, ctl_address_o, ctl_rw_o, ctl_register_o, ctl_data_o}, 0);
    rst_i = 1'b0;

    // Directed write then read
    push_cmd(7'h78, 1'b0, 8'h0F, 8'h55);
    wait_drain(200);
    check_eq("wr_rsp_data", 32'(rsp_data_o), 32'h00);
    check_eq("wr_rsp_error", 32'(rsp_error_o), 0);
    push_cmd(7'h78, 1'b1, 8'h0F, 8'h00);
    wait_drain(200);
    check_eq("rd_rsp_rw", 32'(rsp_rw_o), 1);
    check_eq("rd_rsp_data", 32'(rsp_data_o), 32'hA5);

    // Fill with the controller stalled; first entry sits in launch
    stall = 1'b1;
    base = n_rsp;
    for (int i = 0; i < 5; i++) begin
      push_cmd(7'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      if (i == 3) check_eq("ready_before_full", 32'(cmd_ready_o), 1);
    end
    check_eq("ready_full", 32'(cmd_ready_o), 0);
    check_eq("seq_busy_full", 32'(seq_busy_o), 1);
    fork
      begin
        push_cmd(7'h11, 1'b1, 8'h22, 8'h33);
        check_eq("refill_full_again", 32'(cmd_ready_o), 0);
      end
    join_none
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("full_hold", 32'(cmd_ready_o), 0);
    stall = 1'b0;
    wait_drain(500);
    check_eq("full_rsp_count", 32'(n_rsp - base), 6);

    // Randomized traffic with random gaps
    base = n_rsp;
    for (int i = 0; i < 40; i++) begin
      push_cmd(7'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      n = int'($urandom_range(0, 3));
      repeat (n) @(posedge clk_i);
    end
    wait_drain(2000);
    check_eq("rand_rsp_count", 32'(n_rsp - base), 40);

    // Reset while the controller is busy
    long_mode = 1'b1;
    base = n_rsp;
    push_cmd(7'h42, 1'b1, 8'h10, 8'h00);
    push_cmd(7'h43, 1'b0, 8'h11, 8'h99);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!(ctl_busy_i && !ctl_execute_o) && n < 100);
    check_eq("reach_active_timeout", 32'(n >= 100), 0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    long_mode = 1'b0;
    check_eq("midrst_ready", 32'(cmd_ready_o), 1);
    check_eq("midrst_seq_busy", 32'(seq_busy_o), 0);
    check_eq("midrst_exec", 32'(ctl_execute_o), 0);
    check_eq("midrst_rsp_valid", 32'(rsp_valid_o), 0);
    wait_drain(200);
    repeat (5) @(posedge clk_i);
    check_eq("midrst_no_rsp", 32'(n_rsp - base), 0);
    push_cmd(7'h05, 1'b1, 8'h0F, 8'h00);
    wait_drain(200);
    check_eq("recover_rsp_data", 32'(rsp_data_o), 32'hA5);

`ifdef I2C_SEQ_TIMEOUT_EN
    // Controller never answers: both commands time out in order
    tmo_mode = 1'b1;
    stall = 1'b1;
    base = n_rsp;
    push_cmd(7'h78, 1'b1, 8'h0F, 8'h00);
    push_cmd(7'h79, 1'b0, 8'h01, 8'h02);
    wait_drain(300);
    check_eq("tmo_rsp_count", 32'(n_rsp - base), 2);
    stall = 1'b0;
    tmo_mode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
